// File: rtl/lsio_btn_bank.sv
// lsio_btn_bank: N-channel push-button monitor.
// Each channel synchronises the raw button level and debounces it on the 1 ms
// tick. While the button is held it measures the press length. When the
// button is released, the channel records a sticky "was pressed" flag and the
// longest press so far, quantised to LP_W bits. A sufficiently long press on a
// reset-capable channel raises a sticky system reset request.
module lsio_btn_bank #(
    parameter int              N_CH     = 4,
    parameter int              CNT_W    = 12,
    parameter int              LP_W     = 5,
    parameter int              LP_SHIFT = 6,
    parameter int              DEB_MS   = 4,
    parameter logic [N_CH-1:0] RST_MASK = N_CH'(1),
    parameter int              RST_MS   = 2048
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 one_ms_event_i,
    input  logic [N_CH-1:0]      btn_i,
    input  logic [N_CH-1:0]      clear_i,
    output logic [N_CH-1:0]      pressed_o,
    output logic [N_CH-1:0]      was_pressed_o,
    output logic [N_CH*LP_W-1:0] longest_press_o,
    output logic                 irq_o,
    output logic                 reset_req_o
);

    // Debounce counter only needs to reach DEB_MS-1; keep at least one bit
    // so the design still elaborates when debounce is bypassed.
    localparam int              DEB_W    = (DEB_MS < 2) ? 1 : $clog2(DEB_MS);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'((DEB_MS > 0) ? (DEB_MS - 1) : 0);
    localparam logic [CNT_W-1:0] CUR_MAX  = {CNT_W{1'b1}};
    localparam logic [LP_W-1:0]  LP_MAX   = {LP_W{1'b1}};

    // Press length in ms, shifted down and saturated to the record field width.
    function automatic logic [LP_W-1:0] quantise(input logic [CNT_W-1:0] ms);
        logic [CNT_W-1:0] sh;
        sh = ms >> LP_SHIFT;
        if (sh > CNT_W'(LP_MAX)) begin
            quantise = LP_MAX;
        end else begin
            quantise = sh[LP_W-1:0];
        end
    endfunction

    // Larger of two record values.
    function automatic logic [LP_W-1:0] max_lp(input logic [LP_W-1:0] a,
                                               input logic [LP_W-1:0] b);
        if (a > b) begin
            max_lp = a;
        end else begin
            max_lp = b;
        end
    endfunction

    logic [N_CH-1:0] was_vec_s;
    logic [N_CH-1:0] rst_hit_s;
    logic            reset_req_q;
    logic            reset_req_d;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic             sync1_q,   sync1_d;
        logic             sync2_q,   sync2_d;
        logic             stable_q,  stable_d;
        logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
        logic [CNT_W-1:0] cur_q,     cur_d;
        logic             was_q,     was_d;
        logic [LP_W-1:0]  longest_q, longest_d;
        logic             commit_s;
        logic [LP_W-1:0]  q_s;

        // Two-flop synchroniser for the asynchronous button level.
        always_comb begin
            sync1_d = btn_i[k];
            sync2_d = sync1_q;
        end

        // Debounce: the raw level must differ from the stable level for DEB_MS
        // consecutive ticks; any return to the stable level restarts the count.
        always_comb begin
            stable_d  = stable_q;
            deb_cnt_d = deb_cnt_q;
            if (DEB_MS == 0) begin
                stable_d  = sync2_q;
                deb_cnt_d = '0;
            end else if (sync2_q == stable_q) begin
                deb_cnt_d = '0;
            end else if (one_ms_event_i) begin
                if (deb_cnt_q == DEB_LAST) begin
                    stable_d  = sync2_q;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end else begin
                deb_cnt_d = deb_cnt_q;
            end
        end

        // Press-length counter: saturating ms count while held, zero when idle.
        always_comb begin
            cur_d = cur_q;
            if (!stable_q) begin
                cur_d = '0;
            end else if (one_ms_event_i && (cur_q != CUR_MAX)) begin
                cur_d = cur_q + CNT_W'(1);
            end else begin
                cur_d = cur_q;
            end
        end

        // Release commit: record the press on the 1->0 transition of the
        // debounced level. A simultaneous clear only zeroes the base the
        // commit is merged into, so the fresh press is never lost.
        always_comb begin
            commit_s  = stable_q & ~stable_d;
            q_s       = quantise(cur_q);
            was_d     = was_q;
            longest_d = longest_q;
            if (commit_s) begin
                was_d = 1'b1;
                if (clear_i[k]) begin
                    longest_d = q_s;
                end else begin
                    longest_d = max_lp(longest_q, q_s);
                end
            end else if (clear_i[k]) begin
                was_d     = 1'b0;
                longest_d = '0;
            end else begin
                was_d     = was_q;
                longest_d = longest_q;
            end
        end

        // Reset-request contribution of this channel on its commit cycle.
        always_comb begin
            if (RST_MASK[k] && commit_s && (32'(cur_q) >= 32'(RST_MS))) begin
                rst_hit_s[k] = 1'b1;
            end else begin
                rst_hit_s[k] = 1'b0;
            end
        end

        // Per-channel state registers.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                stable_q  <= 1'b0;
                deb_cnt_q <= '0;
                cur_q     <= '0;
                was_q     <= 1'b0;
                longest_q <= '0;
            end else begin
                sync1_q   <= sync1_d;
                sync2_q   <= sync2_d;
                stable_q  <= stable_d;
                deb_cnt_q <= deb_cnt_d;
                cur_q     <= cur_d;
                was_q     <= was_d;
                longest_q <= longest_d;
            end
        end

        assign pressed_o[k]                    = stable_q;
        assign was_vec_s[k]                    = was_q;
        assign longest_press_o[k*LP_W +: LP_W] = longest_q;
    end

    // Reset request is sticky until the block itself is reset.
    always_comb begin
        if (|rst_hit_s) begin
            reset_req_d = 1'b1;
        end else begin
            reset_req_d = reset_req_q;
        end
    end

    // Reset-request register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reset_req_q <= 1'b0;
        end else begin
            reset_req_q <= reset_req_d;
        end
    end

    assign was_pressed_o = was_vec_s;
    assign irq_o         = |was_vec_s;
    assign reset_req_o   = reset_req_q;

endmodule

// File: tb/tb_lsio_btn_bank.sv
// Directed bench for lsio_btn_bank with default parameters.
// Press helper timing: btn held for (ms+1) ticks gives ms ticks counted at the
// commit (4 debounce ticks on the rising edge, 3 counted ticks on the falling
// edge, commit on the 4th release tick).
module tb_lsio_btn_bank;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        one_ms_event_i;
    logic [3:0]  btn_i;
    logic [3:0]  clear_i;
    logic [3:0]  pressed_o;
    logic [3:0]  was_pressed_o;
    logic [19:0] longest_press_o;
    logic        irq_o;
    logic        reset_req_o;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [3:0]  exp_was;
    logic [19:0] exp_lp;
    logic        exp_rr;

    lsio_btn_bank dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .one_ms_event_i  (one_ms_event_i),
        .btn_i           (btn_i),
        .clear_i         (clear_i),
        .pressed_o       (pressed_o),
        .was_pressed_o   (was_pressed_o),
        .longest_press_o (longest_press_o),
        .irq_o           (irq_o),
        .reset_req_o     (reset_req_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_was"}, 32'(was_pressed_o), 32'(exp_was));
        chk({tag, "_lp"},  32'(longest_press_o), 32'(exp_lp));
        chk({tag, "_irq"}, 32'(irq_o), 32'(|exp_was));
        chk({tag, "_rr"},  32'(reset_req_o), 32'(exp_rr));
    endtask

    task automatic set_lp(input int ch, input logic [4:0] v);
        exp_lp[ch*5 +: 5] = v;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Two idle cycles (covers synchroniser latency) then a one-cycle tick.
    task automatic tick();
        cyc();
        cyc();
        one_ms_event_i = 1'b1;
        cyc();
        one_ms_event_i = 1'b0;
    endtask

    // Press channel ch so that the counter holds ms at commit; clr is driven
    // on clear_i during exactly the commit cycle.
    task automatic press(input int ch, input int ms, input logic [3:0] clr);
        btn_i[ch] = 1'b1;
        repeat (ms + 1) tick();
        chk("held_level", 32'(pressed_o[ch]), 32'd1);
        btn_i[ch] = 1'b0;
        repeat (3) tick();
        chk("still_pressed", 32'(pressed_o[ch]), 32'd1);
        check_outs("pre_commit");
        cyc();
        cyc();
        one_ms_event_i = 1'b1;
        clear_i        = clr;
        cyc();
        one_ms_event_i = 1'b0;
        clear_i        = 4'b0000;
        chk("released", 32'(pressed_o[ch]), 32'd0);
    endtask

    initial begin
        rst_i          = 1'b1;
        one_ms_event_i = 1'b0;
        btn_i          = 4'b1111;
        clear_i        = 4'b0000;
        exp_was        = 4'b0000;
        exp_lp         = 20'd0;
        exp_rr         = 1'b0;
        repeat (3) cyc();
        check_outs("reset");
        chk("reset_pressed", 32'(pressed_o), 32'd0);
        btn_i = 4'b0000;
        cyc();
        rst_i = 1'b0;
        cyc();

        // 1: short bounce on ch0 is filtered.
        btn_i[0] = 1'b1;
        repeat (3) tick();
        chk("t1_pressed_mid", 32'(pressed_o), 32'd0);
        btn_i[0] = 1'b0;
        repeat (5) tick();
        chk("t1_pressed", 32'(pressed_o), 32'd0);
        check_outs("t1");

        // 2: 200 ms on ch1, then shorter 100 ms press, then clear.
        press(1, 200, 4'b0000);
        exp_was = 4'b0010;
        set_lp(1, 5'd3);
        check_outs("t2_200");
        press(1, 100, 4'b0000);
        check_outs("t2_100");
        cyc();
        clear_i = 4'b0010;
        cyc();
        clear_i = 4'b0000;
        exp_was = 4'b0000;
        set_lp(1, 5'd0);
        check_outs("t2_clear");

        // 3: long press on non-reset ch2, then on reset-capable ch0.
        press(2, 2100, 4'b0000);
        exp_was = 4'b0100;
        set_lp(2, 5'd31);
        check_outs("t3_ch2");
        press(0, 2100, 4'b0000);
        exp_was = 4'b0101;
        set_lp(0, 5'd31);
        exp_rr  = 1'b1;
        check_outs("t3_ch0");
        cyc();
        clear_i = 4'b1111;
        cyc();
        clear_i = 4'b0000;
        exp_was = 4'b0000;
        exp_lp  = 20'd0;
        check_outs("t3_clear");

        // 4: clear on the commit cycle merges against a zero base.
        press(3, 200, 4'b0000);
        exp_was = 4'b1000;
        set_lp(3, 5'd3);
        check_outs("t4_first");
        press(3, 130, 4'b1000);
        set_lp(3, 5'd2);
        check_outs("t4_clr_commit");

        // 5: reset mid-press with button held through reset release.
        btn_i[1] = 1'b1;
        repeat (10) tick();
        chk("t5_held", 32'(pressed_o[1]), 32'd1);
        rst_i = 1'b1;
        #1;
        exp_was = 4'b0000;
        exp_lp  = 20'd0;
        exp_rr  = 1'b0;
        check_outs("t5_async");
        chk("t5_pressed_async", 32'(pressed_o), 32'd0);
        cyc();
        cyc();
        rst_i = 1'b0;
        repeat (71) tick();
        btn_i[1] = 1'b0;
        repeat (4) tick();
        exp_was = 4'b0010;
        set_lp(1, 5'd1);
        check_outs("t5_after");

        // 6: overlapping ch0 (300 ms) and ch3 (64 ms), simultaneous release.
        btn_i = 4'b0001;
        repeat (236) tick();
        btn_i = 4'b1001;
        repeat (65) tick();
        btn_i = 4'b0000;
        repeat (3) tick();
        check_outs("t6_pre");
        tick();
        exp_was = 4'b1011;
        set_lp(0, 5'd4);
        set_lp(3, 5'd1);
        check_outs("t6");
        chk("t6_pressed", 32'(pressed_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
